// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - req/gnt + rvalid data-memory bus between the LSU and memory
interface mem_stage_lsu_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: lane steering, load extension, pipeline stall
// One access in flight at a time; the pipeline is held from request until the response completes.
module mem_stage_lsu #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                RegWriteM,
    input  logic [1:0]          ResultSrcM,
    input  logic                MemWriteM,
    input  logic [2:0]          Funct3M,
    input  logic [31:0]         ALUResultM,
    input  logic [31:0]         WriteDataM,
    output logic                StallM,
    output logic [31:0]         ReadDataM,
    mem_stage_lsu_if.master     bus,
    output logic                misalign_fault,
    output logic                bus_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [TO_W-1:0] cnt_q;
    logic            req_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            is_load_q;
    logic [31:0]     rdata_q;
    logic            fault_q;
    logic            berr_q;

    logic            is_store;
    logic            is_load;
    logic            access;
    logic            misaligned;
    logic [31:0]     st_wdata;
    logic [3:0]      st_wstrb;

    // Funct3[1:0] carries the size; Funct3[2] marks the unsigned load forms.
    always_comb begin
        is_store   = MemWriteM;
        is_load    = (ResultSrcM == 2'b01) && RegWriteM;
        access     = is_store || is_load;
        misaligned = 1'b0;
        st_wdata   = WriteDataM;
        st_wstrb   = 4'b1111;
        case (Funct3M[1:0])
            2'b00: begin
                st_wdata = {4{WriteDataM[7:0]}};
                st_wstrb = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                misaligned = ALUResultM[0];
                st_wdata   = {2{WriteDataM[15:0]}};
                st_wstrb   = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                misaligned = (ALUResultM[1:0] != 2'b00);
            end
        endcase
    end

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign StallM = (state_q == S_REQ) || (state_q == S_RESP) ||
                    ((state_q == S_IDLE) && access && !misaligned);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            is_load_q <= 1'b0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            berr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            req_q     <= 1'b1;
                            we_q      <= is_store;
                            addr_q    <= {ALUResultM[31:2], 2'b00};
                            wdata_q   <= st_wdata;
                            wstrb_q   <= is_store ? st_wstrb : 4'b0000;
                            f3_q      <= Funct3M;
                            off_q     <= ALUResultM[1:0];
                            is_load_q <= !is_store;
                            state_q   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_gnt) begin
                        req_q <= 1'b0;
                        if (bus.mem_rvalid) begin
                            if (is_load_q) begin
                                rdata_q <= load_ext(bus.mem_rdata, f3_q, off_q);
                            end
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.mem_rvalid) begin
                        if (is_load_q) begin
                            rdata_q <= load_ext(bus.mem_rdata, f3_q, off_q);
                        end
                        state_q <= S_DONE;
                    end else if (cnt_q == TO_W'(TIMEOUT)) begin
                        // A lost response must not leave stale data looking like a result.
                        berr_q  <= 1'b1;
                        rdata_q <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ReadDataM      = rdata_q;
    assign misalign_fault = fault_q;
    assign bus_error      = berr_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wstrb  = wstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu with a byte-level memory model
module tb_mem_stage_lsu;
    localparam int TIMEOUT = 255;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        RegWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic        MemWriteM = 1'b0;
    logic [2:0]  Funct3M = 3'b000;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        misalign_fault;
    logic        bus_error;

    mem_stage_lsu_if bus();

    mem_stage_lsu #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .RegWriteM      (RegWriteM),
        .ResultSrcM     (ResultSrcM),
        .MemWriteM      (MemWriteM),
        .Funct3M        (Funct3M),
        .ALUResultM     (ALUResultM),
        .WriteDataM     (WriteDataM),
        .StallM         (StallM),
        .ReadDataM      (ReadDataM),
        .bus            (bus),
        .misalign_fault (misalign_fault),
        .bus_error      (bus_error)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb; } bus_t;
    typedef struct { int gd; int rvd; bit to; int late; } rsp_t;
    typedef struct { logic [31:0] rd; bit berr; int stall; } done_t;

    bus_t  bus_q[$];
    rsp_t  rsp_q[$];
    done_t done_q[$];
    bit    fault_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  mdl_mem [logic [31:0]];
    logic [31:0] rsp_mem [logic [31:0]];
    logic [31:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [7:0] mdl_byte(input logic [31:0] a);
        logic [31:0] w;
        if (mdl_mem.exists(a)) return mdl_mem[a];
        w = init_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic logic [31:0] rsp_word(input logic [31:0] wa);
        if (rsp_mem.exists(wa)) return rsp_mem[wa];
        return init_word(wa);
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] v);
        rsp_mem[wa] = v;
        for (int i = 0; i < 4; i++) mdl_mem[wa + 32'(i)] = v[8*i +: 8];
    endtask

    // kind: 0 none, 1 load, 2 store, 3 load+store flags (store wins)
    task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rvd, input bit to);
        bit st, ld;
        int n, k;
        bus_t b;
        done_t d;
        rsp_t r;
        logic [31:0] v;
        st = (kind == 2) || (kind == 3);
        ld = (kind == 1) || (kind == 3);
        MemWriteM = st;
        if (ld) begin
            RegWriteM = 1'b1; ResultSrcM = 2'b01;
        end else if ($urandom_range(0, 1) == 1) begin
            RegWriteM = 1'b0; ResultSrcM = 2'b01;
        end else begin
            RegWriteM = 1'b1; ResultSrcM = 2'b10;
        end
        Funct3M = f3; ALUResultM = a; WriteDataM = wd;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (st || ld) begin
            if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) begin
                fault_q.push_back(1'b1);
                last_rd = '0;
            end else begin
                b.addr = {a[31:2], 2'b00};
                b.we   = st;
                if (st) begin
                    b.wdata = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
                    b.wstrb = 4'(((1 << n) - 1) << a[1:0]);
                    for (int i = 0; i < n; i++) mdl_mem[a + 32'(i)] = wd[8*i +: 8];
                    d.rd = to ? 32'h0 : last_rd;
                end else begin
                    b.wdata = '0;
                    b.wstrb = 4'b0000;
                    v = '0;
                    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl_byte(a + 32'(i));
                    if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                    d.rd = to ? 32'h0 : v;
                end
                last_rd = d.rd;
                d.berr  = to;
                d.stall = to ? (2 + gd + TIMEOUT + 1) : (2 + gd + rvd);
                r.gd = gd; r.rvd = rvd; r.to = to; r.late = 0;
                bus_q.push_back(b);
                rsp_q.push_back(r);
                done_q.push_back(d);
            end
        end
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (StallM && k < 1000);
        if (StallM) check("stall_release", 32'(StallM), 32'h0);
        @(posedge clock);
        #1;
        MemWriteM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 2'b00;
    endtask

    // Memory responder: sees the request in its first REQ cycle and plays back the scripted delays.
    initial begin
        rsp_t r;
        logic [31:0] w;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clock); #2;
            if (reset_n && bus.mem_req && rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                repeat (r.gd) begin @(posedge clock); #2; end
                bus.mem_gnt = 1'b1;
                if (bus.mem_we) begin
                    w = rsp_word(bus.mem_addr);
                    for (int l = 0; l < 4; l++)
                        if (bus.mem_wstrb[l]) w[8*l +: 8] = bus.mem_wdata[8*l +: 8];
                    rsp_mem[bus.mem_addr] = w;
                end
                w = rsp_word(bus.mem_addr);
                if (r.rvd == 0 && !r.to) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = w; end
                @(posedge clock); #2;
                bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
                if (!r.to && r.rvd > 0) begin
                    repeat (r.rvd - 1) begin @(posedge clock); #2; end
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = w;
                    @(posedge clock); #2;
                    bus.mem_rvalid = 1'b0;
                end
                if (r.to && r.late > 0) begin
                    repeat (r.late - 1) begin @(posedge clock); #2; end
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
                    repeat (3) begin @(posedge clock); #2; end
                    bus.mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Monitor: checks bus transfers, fault pulses and access completions against the queues.
    initial begin
        bit    prev = 1'b0;
        int    scnt = 0;
        bus_t  b;
        done_t d;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev = 1'b0; scnt = 0;
            end else begin
                if (bus.mem_req && bus.mem_gnt) begin
                    if (bus_q.size() == 0) flag("unexpected_req");
                    else begin
                        b = bus_q.pop_front();
                        check("mem_addr", bus.mem_addr, b.addr);
                        check("mem_we", 32'(bus.mem_we), 32'(b.we));
                        check("mem_wstrb", 32'(bus.mem_wstrb), 32'(b.wstrb));
                        if (b.we) check("mem_wdata", bus.mem_wdata, b.wdata);
                    end
                end
                if (misalign_fault) begin
                    if (fault_q.size() == 0) flag("unexpected_fault");
                    else begin
                        void'(fault_q.pop_front());
                        check("fault_rdata", ReadDataM, 32'h0);
                    end
                end
                if (StallM) scnt++;
                if (prev && !StallM) begin
                    if (done_q.size() == 0) flag("unexpected_done");
                    else begin
                        d = done_q.pop_front();
                        check("ReadDataM", ReadDataM, d.rd);
                        check("bus_error", 32'(bus_error), 32'(d.berr));
                        check("stall_cycles", 32'(scnt), 32'(d.stall));
                    end
                    scnt = 0;
                end else if (bus_error) begin
                    flag("unexpected_bus_error");
                end
                prev = StallM;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, gd, rvd;
        logic [2:0] f3;
        logic [2:0] ld_f3 [5];
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

        repeat (3) @(negedge clock);
        check("rst_StallM", 32'(StallM), 32'h0);
        check("rst_ReadDataM", ReadDataM, 32'h0);
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        check("rst_fault", 32'(misalign_fault), 32'h0);
        check("rst_bus_error", 32'(bus_error), 32'h0);
        #2 reset_n = 1'b1;
        @(posedge clock); #1;

        preload(32'h100, 32'h80FF1234);
        issue(2, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 0);
        issue(1, 3'b000, 32'h103, 32'h0, 0, 0, 0);
        issue(1, 3'b100, 32'h103, 32'h0, 1, 2, 0);
        issue(2, 3'b001, 32'h102, 32'h0000ABCD, 0, 0, 0);
        issue(1, 3'b010, 32'h101, 32'h0, 0, 0, 0);
        issue(1, 3'b010, 32'h100, 32'h0, 1, 0, 1);
        issue(1, 3'b010, 32'h100, 32'h0, 2, 3, 0);
        issue(1, 3'b001, 32'h102, 32'h0, 0, 1, 0);
        issue(1, 3'b101, 32'h102, 32'h0, 0, 0, 0);
        issue(1, 3'b010, 32'h104, 32'h0, 0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) kind = 0;
            else if (kind <= 4) kind = 1;
            else if (kind <= 8) kind = 2;
            else kind = 3;
            if (kind == 1) f3 = ld_f3[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            gd  = $urandom_range(0, 3);
            rvd = $urandom_range(0, 3);
            issue(kind, f3, 32'h200 + 32'($urandom_range(0, 63)), $urandom, gd, rvd, 0);
        end

        repeat (3) @(negedge clock);
        check("done_q_empty", 32'(done_q.size()), 32'h0);
        check("fault_q_empty", 32'(fault_q.size()), 32'h0);
        check("bus_q_empty", 32'(bus_q.size()), 32'h0);

        // Reset while waiting for a response; the late rvalid must be ignored.
        @(posedge clock); #1;
        begin
            bus_t b;
            rsp_t r;
            MemWriteM = 1'b0; RegWriteM = 1'b1; ResultSrcM = 2'b01;
            Funct3M = 3'b010; ALUResultM = 32'h300; WriteDataM = 32'h0;
            b.addr = 32'h300; b.we = 1'b0; b.wdata = '0; b.wstrb = 4'b0000;
            r.gd = 0; r.rvd = 0; r.to = 1'b1; r.late = 3;
            bus_q.push_back(b);
            rsp_q.push_back(r);
        end
        repeat (4) @(negedge clock);
        check("resp_stall", 32'(StallM), 32'h1);
        #2;
        RegWriteM = 1'b0; ResultSrcM = 2'b00;
        reset_n = 1'b0;
        #1;
        check("mid_rst_StallM", 32'(StallM), 32'h0);
        check("mid_rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("mid_rst_mem_addr", bus.mem_addr, 32'h0);
        check("mid_rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        check("mid_rst_ReadDataM", ReadDataM, 32'h0);
        @(negedge clock); #2;
        reset_n = 1'b1;
        last_rd = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("late_ReadDataM", ReadDataM, 32'h0);
            check("late_StallM", 32'(StallM), 32'h0);
            check("late_mem_req", 32'(bus.mem_req), 32'h0);
        end
        check("final_rsp_q_empty", 32'(rsp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
